// File: rtl/rtc_access_sched_pkg.sv
// Shared definitions for the RTC access scheduler: FSM encoding, default
// register addresses and the idx -> register address mapping.
// Pure package, no timing or flow-control behaviour of its own.
package rtc_access_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] DEF_ADDR_SEC  = 8'h21;
    localparam logic [7:0] DEF_ADDR_MIN  = 8'h22;
    localparam logic [7:0] DEF_ADDR_HOUR = 8'h23;

    // Sequence order within a three-command access: seconds, minutes, hours.
    localparam logic [1:0] IDX_SEC  = 2'd0;
    localparam logic [1:0] IDX_MIN  = 2'd1;
    localparam logic [1:0] IDX_HOUR = 2'd2;

    function automatic logic [7:0] idx_to_addr(input logic [1:0] idx,
                                               input logic [7:0] a_sec,
                                               input logic [7:0] a_min,
                                               input logic [7:0] a_hour);
        logic [7:0] a;
        case (idx)
            IDX_SEC: a = a_sec;
            IDX_MIN: a = a_min;
            default: a = a_hour;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rtc_access_sched_timer.sv
// Free-running wrap counter 0..PERIOD-1; tick is high for the cycle in which
// the count sits at PERIOD-1 (the cycle whose closing edge wraps it to 0).
// No backpressure: ticks are never held or queued here.
// Ports: clk, reset (async, active-high), tick_o (1-cycle wrap pulse).
module rtc_period_timer #(
    parameter int unsigned PERIOD = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);
    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/rtc_access_sched.sv
// Sole owner of the RTC bus-cycle engine: periodic H/M/S snapshot reads and
// queued write-back of edited time, three byte commands per sequence.
// Latency: one idle cycle between commands; cmd_valid held until cmd_done or timeout.
// Ports: clk/reset; edit_en, commit, wr_h/m/s from the edit path; cmd_* to/from
// the engine; H/M/S + time_valid snapshot; wr_done, busy, err status.
module rtc_access_sched
    import rtc_access_sched_pkg::*;
#(
    parameter int unsigned READ_PERIOD = 100000,
    parameter int unsigned TIMEOUT     = 1023,
    parameter logic [7:0]  ADDR_SEC    = DEF_ADDR_SEC,
    parameter logic [7:0]  ADDR_MIN    = DEF_ADDR_MIN,
    parameter logic [7:0]  ADDR_HOUR   = DEF_ADDR_HOUR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       edit_en,
    input  logic       commit,
    input  logic [7:0] wr_h,
    input  logic [7:0] wr_m,
    input  logic [7:0] wr_s,
    output logic       cmd_valid,
    output logic       cmd_wr,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_wdata,
    input  logic       cmd_done,
    input  logic [7:0] cmd_rdata,
    output logic [7:0] H,
    output logic [7:0] M,
    output logic [7:0] S,
    output logic       time_valid,
    output logic       wr_done,
    output logic       busy,
    output logic       err
);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic            tick;
    state_t          state_q;
    logic [1:0]      idx_q;
    logic            op_wr_q;
    logic [TW-1:0]   tmo_q;
    logic            rd_pend_q, wr_pend_q, retry_q;
    logic [2:0][7:0] wbuf_q;      // [0]=sec [1]=min [2]=hour, as captured on commit
    logic [2:0][7:0] wact_q;      // copy in flight, immune to commits mid-sequence
    logic [1:0][7:0] shadow_q;    // sec/min of the read in progress
    logic [7:0]      h_q, m_q, s_q;
    logic            cmd_valid_q, cmd_wr_q;
    logic [7:0]      cmd_addr_q, cmd_wdata_q;
    logic            time_valid_q, wr_done_q, err_q;

    rtc_period_timer #(.PERIOD(READ_PERIOD)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= IDX_SEC;
            op_wr_q      <= 1'b0;
            tmo_q        <= '0;
            rd_pend_q    <= 1'b0;
            wr_pend_q    <= 1'b0;
            retry_q      <= 1'b0;
            wbuf_q       <= '0;
            wact_q       <= '0;
            shadow_q     <= '0;
            h_q          <= '0;
            m_q          <= '0;
            s_q          <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_wr_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            time_valid_q <= 1'b0;
            wr_done_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            time_valid_q <= 1'b0;
            wr_done_q    <= 1'b0;
            err_q        <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Writes win; cmd_done arriving here is simply ignored.
                    if (wr_pend_q) begin
                        state_q   <= ST_ISSUE;
                        op_wr_q   <= 1'b1;
                        idx_q     <= IDX_SEC;
                        wr_pend_q <= 1'b0;
                        wact_q    <= wbuf_q;
                    end else if (rd_pend_q) begin
                        state_q   <= ST_ISSUE;
                        op_wr_q   <= 1'b0;
                        idx_q     <= IDX_SEC;
                        rd_pend_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    // cmd_valid is low during this cycle, which gives the
                    // mandatory idle gap between back-to-back commands.
                    cmd_valid_q <= 1'b1;
                    cmd_wr_q    <= op_wr_q;
                    cmd_addr_q  <= idx_to_addr(idx_q, ADDR_SEC, ADDR_MIN, ADDR_HOUR);
                    cmd_wdata_q <= op_wr_q ? wact_q[idx_q] : 8'h00;
                    tmo_q       <= '0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cmd_done) begin
                        cmd_valid_q <= 1'b0;
                        if (idx_q == IDX_HOUR) begin
                            state_q <= ST_IDLE;
                            if (op_wr_q) begin
                                wr_done_q <= 1'b1;
                                rd_pend_q <= 1'b1;   // read back what was written
                                retry_q   <= 1'b0;
                            end else begin
                                h_q          <= cmd_rdata;
                                m_q          <= shadow_q[1];
                                s_q          <= shadow_q[0];
                                time_valid_q <= 1'b1;
                            end
                        end else begin
                            if (!op_wr_q) shadow_q[idx_q[0]] <= cmd_rdata;
                            idx_q   <= idx_q + 2'd1;
                            state_q <= ST_ISSUE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        cmd_valid_q <= 1'b0;
                        err_q       <= 1'b1;
                        state_q     <= ST_IDLE;
                        // A failed write gets exactly one more attempt.
                        if (op_wr_q && !retry_q) begin
                            wr_pend_q <= 1'b1;
                            retry_q   <= 1'b1;
                        end else if (op_wr_q) begin
                            retry_q   <= 1'b0;
                        end
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Request sources come last so a same-cycle set beats the
            // arbitration clear above.
            if (tick && !edit_en) rd_pend_q <= 1'b1;
            if (commit) begin
                wbuf_q    <= {wr_h, wr_m, wr_s};
                wr_pend_q <= 1'b1;
                retry_q   <= 1'b0;
            end
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_wr     = cmd_wr_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_wdata  = cmd_wdata_q;
    assign H          = h_q;
    assign M          = m_q;
    assign S          = s_q;
    assign time_valid = time_valid_q;
    assign wr_done    = wr_done_q;
    assign err        = err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rtc_access_sched.sv
// Scoreboard bench for rtc_access_sched: stimulus pushes expected events,
// a negedge monitor pops and compares each command / time_valid / wr_done / err.
// The bus-cycle engine is a small register file answering with 2-cycle latency.
module tb_rtc_access_sched;

    localparam logic [3:0] EV_CMD = 4'd1;
    localparam logic [3:0] EV_TV  = 4'd2;
    localparam logic [3:0] EV_WD  = 4'd3;
    localparam logic [3:0] EV_ER  = 4'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       edit_en = 1'b1;
    logic       commit = 1'b0;
    logic [7:0] wr_h = '0, wr_m = '0, wr_s = '0;
    logic       cmd_valid, cmd_wr;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       cmd_done;
    logic [7:0] cmd_rdata;
    logic [7:0] H, M, S;
    logic       time_valid, wr_done, busy, err;

    int vectors = 0;
    int miscompares = 0;
    logic [35:0] exp_q[$];
    logic        eng_respond = 1'b1;
    logic [7:0]  rf [3];
    logic [3:0]  tcnt;

    rtc_access_sched #(.READ_PERIOD(16), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .edit_en(edit_en), .commit(commit),
        .wr_h(wr_h), .wr_m(wr_m), .wr_s(wr_s),
        .cmd_valid(cmd_valid), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_done(cmd_done), .cmd_rdata(cmd_rdata),
        .H(H), .M(M), .S(S), .time_valid(time_valid), .wr_done(wr_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Phase of the period timer, used only to line a commit up with a wrap.
    always @(posedge clk or posedge reset) begin
        if (reset) tcnt <= 4'd0;
        else       tcnt <= tcnt + 4'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] ev(input logic [3:0] k, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c,
                                       input logic [7:0] d);
        return {k, a, b, c, d};
    endfunction

    task automatic exp_rd_seq(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        exp_q.push_back(ev(EV_CMD, 8'd0, 8'h21, 8'h00, 8'h00));
        exp_q.push_back(ev(EV_CMD, 8'd0, 8'h22, 8'h00, 8'h00));
        exp_q.push_back(ev(EV_CMD, 8'd0, 8'h23, 8'h00, 8'h00));
        exp_q.push_back(ev(EV_TV, 8'd0, h, m, s));
    endtask

    task automatic exp_wr_seq(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        exp_q.push_back(ev(EV_CMD, 8'd1, 8'h21, s, 8'h00));
        exp_q.push_back(ev(EV_CMD, 8'd1, 8'h22, m, 8'h00));
        exp_q.push_back(ev(EV_CMD, 8'd1, 8'h23, h, 8'h00));
        exp_q.push_back(ev(EV_WD, 8'd0, 8'h00, 8'h00, 8'h00));
    endtask

    task automatic take(input string name, input logic [35:0] act);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_%s: got %0h expected no event", name, act);
        end else begin
            chk(name, 64'(act), 64'(exp_q.pop_front()));
        end
    endtask

    // Monitor: one event per command start and per status pulse.
    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                if (cmd_valid && !prev_v)
                    take("cmd", ev(EV_CMD, {7'd0, cmd_wr}, cmd_addr,
                                   cmd_wr ? cmd_wdata : 8'h00, 8'h00));
                if (time_valid) take("time_valid", ev(EV_TV, 8'd0, H, M, S));
                if (wr_done)    take("wr_done", ev(EV_WD, 8'd0, 8'h00, 8'h00, 8'h00));
                if (err)        take("err", ev(EV_ER, 8'd0, 8'h00, 8'h00, 8'h00));
                prev_v = cmd_valid;
            end
        end
    end

    // Bus-cycle engine: register file at 0x21..0x23, done two cycles after valid.
    initial begin
        logic       e_wr;
        logic [7:0] e_addr, e_wd;
        cmd_done  = 1'b0;
        cmd_rdata = 8'h00;
        rf[0] = 8'h45; rf[1] = 8'h30; rf[2] = 8'h12;
        forever begin
            @(negedge clk);
            if (!reset && eng_respond && cmd_valid) begin
                e_wr = cmd_wr; e_addr = cmd_addr; e_wd = cmd_wdata;
                repeat (2) @(negedge clk);
                cmd_done = 1'b1;
                if (e_addr >= 8'h21 && e_addr <= 8'h23) begin
                    if (e_wr) rf[int'(e_addr - 8'h21)] = e_wd;
                    else      cmd_rdata = rf[int'(e_addr - 8'h21)];
                end
                @(negedge clk);
                cmd_done  = 1'b0;
                cmd_rdata = 8'h00;
            end
        end
    end

    task automatic wait_cmd(input logic [7:0] addr, input string name);
        int n;
        n = 0;
        while (!(cmd_valid && cmd_addr == addr) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no command to %0h within 100 cycles", name, addr);
        end
    endtask

    task automatic do_commit(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        wr_h = h; wr_m = m; wr_s = s;
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    // Let exactly one timer wrap through, then mask further wraps.
    task automatic one_periodic_read(input string name);
        edit_en = 1'b0;
        wait_cmd(8'h21, name);
        edit_en = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (40) @(negedge clk);
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hms", 64'({H, M, S}), 64'd0);
        chk("rst_pulses", 64'({time_valid, wr_done, err}), 64'd0);
        chk("rst_cmd_bus", 64'({cmd_wr, cmd_addr, cmd_wdata}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: first periodic read
        exp_rd_seq(8'h12, 8'h30, 8'h45);
        one_periodic_read("t1_read");
        drain("t1_drain");

        // 2: edit mode across two wraps
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_valid) n++;
        end
        chk("t2_no_cmd", 64'(n), 64'd0);
        chk("t2_hms_hold", 64'({H, M, S}), 64'h123045);

        // 3: commit during read idx=1
        exp_rd_seq(8'h12, 8'h30, 8'h45);
        exp_wr_seq(8'h09, 8'h15, 8'h00);
        exp_rd_seq(8'h09, 8'h15, 8'h00);
        one_periodic_read("t3_read");
        wait_cmd(8'h22, "t3_idx1");
        do_commit(8'h09, 8'h15, 8'h00);
        drain("t3_drain");

        // 4: commit and wrap in the same cycle
        exp_wr_seq(8'h08, 8'h59, 8'h58);
        exp_rd_seq(8'h08, 8'h59, 8'h58);
        n = 0;
        while (tcnt != 4'd15 && n < 40) begin
            @(negedge clk);
            n++;
        end
        edit_en = 1'b0;
        do_commit(8'h08, 8'h59, 8'h58);
        edit_en = 1'b1;
        drain("t4_drain");

        // 5: two commits before service, last one wins
        exp_rd_seq(8'h08, 8'h59, 8'h58);
        exp_wr_seq(8'h11, 8'h20, 8'h33);
        exp_rd_seq(8'h11, 8'h20, 8'h33);
        one_periodic_read("t5_read");
        do_commit(8'h07, 8'h20, 8'h33);
        do_commit(8'h11, 8'h20, 8'h33);
        drain("t5_drain");

        // 6: engine silent -> timeout, one retry, then dropped
        eng_respond = 1'b0;
        exp_q.push_back(ev(EV_CMD, 8'd1, 8'h21, 8'h03, 8'h00));
        exp_q.push_back(ev(EV_ER, 8'd0, 8'h00, 8'h00, 8'h00));
        exp_q.push_back(ev(EV_CMD, 8'd1, 8'h21, 8'h03, 8'h00));
        exp_q.push_back(ev(EV_ER, 8'd0, 8'h00, 8'h00, 8'h00));
        do_commit(8'h01, 8'h02, 8'h03);
        wait_cmd(8'h21, "t6_first");
        n = 0;
        while (cmd_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t6_wait_cycles", 64'(n), 64'd8);
        drain("t6_drain");
        chk("t6_hms_hold", 64'({H, M, S}), 64'h112033);

        // 7: async reset in the middle of WAIT
        exp_q.push_back(ev(EV_CMD, 8'd0, 8'h21, 8'h00, 8'h00));
        one_periodic_read("t7_read");
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t7_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("t7_hms", 64'({H, M, S}), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("t7_queue", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
